// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end that issues word fetches, queues PC-tagged responses for ID,
// and discards stale responses after a redirect. Define FETCH_QUEUE_BYPASS_EN to forward into an empty queue.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t           r_q [DEPTH];
  logic [31:0]      r_pf [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, r_pf_rd, r_pf_wr;
  logic [CNT_W-1:0] r_count, r_pend, r_drop;
  logic [31:0]      r_pc;
  logic             r_halt;

  logic   w_room, w_aligned, w_fire;
  logic   w_resp_keep, w_resp_drop, w_adel_push;
  logic   w_byp_take, w_push, w_pop;
  entry_t w_head, w_push_entry;

  // Slots are reserved at issue time, so every kept response is guaranteed a free entry.
  assign w_room    = ({1'b0, r_count} + {1'b0, r_pend}) < {1'b0, DEPTH_C};
  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign inst_req  = ~rst & ~flush & ~r_halt & w_room & w_aligned;
  assign inst_addr = r_pc;
  assign w_fire    = inst_req & inst_addr_ok;

  assign w_resp_drop = inst_data_ok & (r_drop != '0);
  assign w_resp_keep = inst_data_ok & (r_drop == '0) & ~flush;
  assign w_adel_push = ~flush & ~r_halt & ~w_aligned & (r_pend == '0) & (r_count < DEPTH_C);
  assign w_head      = r_q[r_rd_ptr];

  always_comb begin
    id_valid   = (r_count != '0);
    id_pc      = w_head.pc;
    id_inst    = w_head.inst;
    id_adel    = w_head.adel;
    w_byp_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_resp_keep && (r_count == '0)) begin
      id_valid   = 1'b1;
      id_pc      = r_pf[r_pf_rd];
      id_inst    = inst_rdata;
      id_adel    = 1'b0;
      w_byp_take = id_ready;
    end
`endif
  end

  assign w_push = (w_resp_keep & ~w_byp_take) | w_adel_push;
  assign w_pop  = (r_count != '0) & id_ready & ~flush;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.pc   = r_pf[r_pf_rd];
    w_push_entry.inst = inst_rdata;
    if (w_adel_push) begin
      w_push_entry.pc   = r_pc;
      w_push_entry.inst = 32'h0;
      w_push_entry.adel = 1'b1;
    end
  end

  // NOTE: the PC FIFO storage has no reset; its pointers and r_pend alone decide which words are ever read.
  always_ff @(posedge clk) begin
    if (w_fire) r_pf[r_pf_wr] <= r_pc;
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halt   <= 1'b0;
      r_count  <= '0;
      r_pend   <= '0;
      r_drop   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_pf_rd  <= '0;
      r_pf_wr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
    end else if (flush) begin
      r_pc     <= flush_pc;
      r_halt   <= 1'b0;
      r_count  <= '0;
      r_pend   <= '0;
      r_drop   <= r_drop + r_pend - CNT_W'(inst_data_ok);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_pf_rd  <= '0;
      r_pf_wr  <= '0;
    end else begin
      if (w_fire) begin
        r_pc    <= r_pc + 32'd4;
        r_pf_wr <= r_pf_wr + PTR_W'(1);
      end
      if (w_resp_keep) r_pf_rd <= r_pf_rd + PTR_W'(1);
      if (w_adel_push) r_halt <= 1'b1;
      if (w_push) begin
        r_q[r_wr_ptr] <= w_push_entry;
        r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_pend  <= r_pend + CNT_W'(w_fire) - CNT_W'(w_resp_keep);
      r_drop  <= r_drop - CNT_W'(w_resp_drop);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule
